// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C sequencer: START/STOP/WRITE/READ, each as four timer-paced quarter phases.
// Optional clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_bit_ctrl #(
    parameter int unsigned SIZE = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [2:0]      Cmd,
    input  logic            CmdValid,
    output logic            CmdReady,
    input  logic [SIZE-1:0] Divider,
    input  logic            DinBit,
    output logic            DoutBit,
    output logic            Done,
    output logic            ArbLost,
    output logic            Busy,
    input  logic            SclIn,
    input  logic            SdaIn,
    output logic            SclOe,
    output logic            SdaOe,
    output logic            TmrStart,
    output logic            TmrStop,
    output logic [SIZE-1:0] TmrTicks,
    input  logic            TmrOut
);

    localparam logic [2:0] CMD_START = 3'b001;
    localparam logic [2:0] CMD_STOP  = 3'b010;
    localparam logic [2:0] CMD_WRITE = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b100;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH_A = 3'd1,
        PH_B = 3'd2,
        PH_C = 3'd3,
        PH_D = 3'd4
    } state_t;

    state_t     state;
    state_t     nxt_phase;
    logic [2:0] cmd_q;
    logic       din_q;
    logic       arb_hit;
    logic       is_bus_cmd;

    // Open-drain enables {sda_oe, scl_oe} for a command in a given phase; 1 = pull low.
    function automatic logic [1:0] line_oe(input logic [2:0] cmd, input state_t ph,
                                           input logic din, input logic scl_prev);
        logic [1:0] oe;
        oe = 2'b00;
        case (cmd)
            CMD_START: begin
                case (ph)
                    PH_A:    oe = {1'b0, scl_prev};
                    PH_B:    oe = 2'b00;
                    PH_C:    oe = 2'b10;
                    PH_D:    oe = 2'b11;
                    default: oe = 2'b00;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    PH_A:    oe = 2'b11;
                    PH_B:    oe = 2'b10;
                    default: oe = 2'b00;
                endcase
            end
            CMD_WRITE, CMD_READ: begin
                oe[1] = (cmd == CMD_WRITE) ? ~din : 1'b0;
                oe[0] = (ph == PH_A) || (ph == PH_D);
            end
            default: oe = 2'b00;
        endcase
        return oe;
    endfunction

    always_comb begin
        nxt_phase = IDLE;
        case (state)
            PH_A:    nxt_phase = PH_B;
            PH_B:    nxt_phase = PH_C;
            PH_C:    nxt_phase = PH_D;
            default: nxt_phase = IDLE;
        endcase
    end

    assign is_bus_cmd = (Cmd == CMD_START) || (Cmd == CMD_STOP) ||
                        (Cmd == CMD_WRITE) || (Cmd == CMD_READ);

    // SDA released by us but seen low at the end of a sampling phase means another master won.
    assign arb_hit = TmrOut && !SdaIn &&
                     (((cmd_q == CMD_WRITE) && din_q && ((state == PH_B) || (state == PH_C))) ||
                      ((cmd_q == CMD_STOP) && (state == PH_C)));

`ifndef I2C_CLK_STRETCH_EN
    logic unused_scl_in;
    assign unused_scl_in = SclIn;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cmd_q    <= 3'b000;
            din_q    <= 1'b0;
            SclOe    <= 1'b0;
            SdaOe    <= 1'b0;
            CmdReady <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ArbLost  <= 1'b0;
            DoutBit  <= 1'b0;
            TmrStart <= 1'b0;
            TmrStop  <= 1'b1;
            TmrTicks <= '0;
        end else begin
            Done     <= 1'b0;
            ArbLost  <= 1'b0;
            TmrStart <= 1'b0;
            case (state)
                IDLE: begin
                    CmdReady <= 1'b1;
                    Busy     <= 1'b0;
                    TmrStop  <= 1'b1;
                    if (CmdValid && CmdReady) begin
                        if (is_bus_cmd) begin
                            state          <= PH_A;
                            cmd_q          <= Cmd;
                            din_q          <= DinBit;
                            TmrTicks       <= (Divider == '0) ? SIZE'(1) : Divider;
                            TmrStart       <= 1'b1;
                            TmrStop        <= 1'b0;
                            CmdReady       <= 1'b0;
                            Busy           <= 1'b1;
                            {SdaOe, SclOe} <= line_oe(Cmd, PH_A, DinBit, SclOe);
                        end else begin
                            Done <= 1'b1;
                        end
                    end
                end
                PH_A, PH_B, PH_C, PH_D: begin
`ifdef I2C_CLK_STRETCH_EN
                    // A slave holding SCL low while we release it freezes the phase timer.
                    TmrStop <= !SclOe && !SclIn;
`else
                    TmrStop <= 1'b0;
`endif
                    if (TmrOut) begin
                        if ((state == PH_B) && (cmd_q == CMD_READ)) begin
                            DoutBit <= SdaIn;
                        end
                        if (arb_hit) begin
                            state    <= IDLE;
                            ArbLost  <= 1'b1;
                            SclOe    <= 1'b0;
                            SdaOe    <= 1'b0;
                            Busy     <= 1'b0;
                            CmdReady <= 1'b1;
                            TmrStop  <= 1'b1;
                        end else if (state == PH_D) begin
                            state    <= IDLE;
                            Done     <= 1'b1;
                            Busy     <= 1'b0;
                            CmdReady <= 1'b1;
                            TmrStop  <= 1'b1;
                        end else begin
                            state          <= nxt_phase;
                            TmrStart       <= 1'b1;
                            {SdaOe, SclOe} <= line_oe(cmd_q, nxt_phase, din_q, SclOe);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    SclOe    <= 1'b0;
                    SdaOe    <= 1'b0;
                    Busy     <= 1'b0;
                    CmdReady <= 1'b1;
                    TmrStop  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Self-checking bench for i2c_bit_ctrl with a behavioural phase timer and a result scoreboard.
module tb_i2c_bit_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [2:0] Cmd;
    logic       CmdValid;
    logic       CmdReady;
    logic [7:0] Divider;
    logic       DinBit;
    logic       DoutBit;
    logic       Done;
    logic       ArbLost;
    logic       Busy;
    logic       SclIn;
    logic       SdaIn;
    logic       SclOe;
    logic       SdaOe;
    logic       TmrStart;
    logic       TmrStop;
    logic [7:0] TmrTicks;
    logic       TmrOut = 1'b0;
    logic [7:0] tcnt = 8'd0;
    logic       sda_force0 = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic arb;
        logic dout;
        logic chk_dout;
        int   cycles;
        int   starts;
    } exp_t;

    exp_t exp_q[$];

    i2c_bit_ctrl #(.SIZE(8)) dut (
        .Clk(Clk), .Rst(Rst), .Cmd(Cmd), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .Divider(Divider), .DinBit(DinBit), .DoutBit(DoutBit), .Done(Done),
        .ArbLost(ArbLost), .Busy(Busy), .SclIn(SclIn), .SdaIn(SdaIn),
        .SclOe(SclOe), .SdaOe(SdaOe), .TmrStart(TmrStart), .TmrStop(TmrStop),
        .TmrTicks(TmrTicks), .TmrOut(TmrOut)
    );

    always #5 Clk = ~Clk;

    assign SclIn = !SclOe;
    assign SdaIn = sda_force0 ? 1'b0 : !SdaOe;

    // Phase timer: loads on TmrStart, counts down while not stopped, pulses TmrOut at expiry.
    always @(posedge Clk) begin
        if (TmrStart) begin
            tcnt   <= TmrTicks;
            TmrOut <= 1'b0;
        end else if (!TmrStop && tcnt == 8'd1) begin
            tcnt   <= 8'd0;
            TmrOut <= 1'b1;
        end else begin
            TmrOut <= 1'b0;
            if (!TmrStop && tcnt != 8'd0) tcnt <= tcnt - 8'd1;
        end
    end

    function automatic int full_cycles(input logic [7:0] div);
        int n;
        n = (div == 8'd0) ? 1 : int'(div);
        return 4 * (n + 2);
    endfunction

    task automatic issue(input string name, input logic [2:0] c, input logic d,
                         input logic [7:0] div, input exp_t e,
                         output int sda_fall_scl_hi, output logic sda_oe_seen);
        int   k;
        int   starts;
        logic got;
        logic prev_sda;
        logic [7:0] exp_ticks;
        exp_t x;
        @(negedge Clk);
        checks++;
        if (CmdReady !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, CmdReady);
        end
        Cmd = c; DinBit = d; Divider = div; CmdValid = 1'b1;
        exp_q.push_back(e);
        @(negedge Clk);
        CmdValid = 1'b0; Cmd = 3'b000;
        if (e.starts > 0) begin
            exp_ticks = (div == 8'd0) ? 8'd1 : div;
            checks++;
            if (Busy !== 1'b1 || CmdReady !== 1'b0 || TmrTicks !== exp_ticks || TmrStop !== 1'b0) begin
                errors++;
                $display("FAIL %s accept: busy=%b ready=%b ticks=%0d stop=%b want 1 0 %0d 0",
                         name, Busy, CmdReady, TmrTicks, TmrStop, exp_ticks);
            end
        end
        k = 0; starts = 0; got = 1'b0; prev_sda = SdaOe;
        sda_fall_scl_hi = 0; sda_oe_seen = 1'b0;
        while (!got && k < 1000) begin
            if (TmrStart) starts++;
            if (SdaOe) sda_oe_seen = 1'b1;
            if (!prev_sda && SdaOe && !SclOe) sda_fall_scl_hi++;
            prev_sda = SdaOe;
            if (Done || ArbLost) got = 1'b1;
            else begin
                @(negedge Clk);
                k++;
            end
        end
        x = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no Done/ArbLost after %0d cycles", name, k);
        end else begin
            if (ArbLost !== x.arb || Done !== !x.arb) begin
                errors++;
                $display("FAIL %s outcome: done=%b arb=%b want arb=%b", name, Done, ArbLost, x.arb);
            end
            checks++;
            if (k != x.cycles || starts != x.starts) begin
                errors++;
                $display("FAIL %s timing: cycles=%0d starts=%0d want %0d %0d",
                         name, k, starts, x.cycles, x.starts);
            end
            if (x.chk_dout) begin
                checks++;
                if (DoutBit !== x.dout) begin
                    errors++;
                    $display("FAIL %s dout: got %b want %b", name, DoutBit, x.dout);
                end
            end
            if (x.arb) begin
                checks++;
                if (SclOe !== 1'b0 || SdaOe !== 1'b0 || Busy !== 1'b0 || CmdReady !== 1'b1) begin
                    errors++;
                    $display("FAIL %s arb_release: scl=%b sda=%b busy=%b ready=%b want 0 0 0 1",
                             name, SclOe, SdaOe, Busy, CmdReady);
                end
            end
        end
        @(negedge Clk);
        checks++;
        if (Done !== 1'b0 || ArbLost !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width: done=%b arb=%b want 0 0", name, Done, ArbLost);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Cmd = 3'b000; CmdValid = 1'b0; Divider = 8'd0; DinBit = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (SclOe !== 1'b0 || SdaOe !== 1'b0 || CmdReady !== 1'b0 || Busy !== 1'b0 ||
            Done !== 1'b0 || ArbLost !== 1'b0 || DoutBit !== 1'b0 || TmrStart !== 1'b0 ||
            TmrStop !== 1'b1 || TmrTicks !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: scl=%b sda=%b rdy=%b busy=%b done=%b arb=%b dout=%b st=%b sp=%b ticks=%0d",
                     SclOe, SdaOe, CmdReady, Busy, Done, ArbLost, DoutBit, TmrStart, TmrStop, TmrTicks);
        end
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (CmdReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", CmdReady);
        end
    endtask

    task automatic test_start_write();
        exp_t e;
        int   fall;
        logic seen;
        e = '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b0, cycles: full_cycles(8'd4), starts: 4};
        issue("start", 3'b001, 1'b0, 8'd4, e, fall, seen);
        checks++;
        if (fall != 1 || SclOe !== 1'b1 || SdaOe !== 1'b1) begin
            errors++;
            $display("FAIL start_lines: falls_scl_high=%0d scl=%b sda=%b want 1 1 1", fall, SclOe, SdaOe);
        end
        issue("write0", 3'b011, 1'b0, 8'd4, e, fall, seen);
        checks++;
        if (SdaOe !== 1'b1 || SclOe !== 1'b1) begin
            errors++;
            $display("FAIL write0_lines: scl=%b sda=%b want 1 1", SclOe, SdaOe);
        end
        issue("stop", 3'b010, 1'b0, 8'd3, '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b0,
              cycles: full_cycles(8'd3), starts: 4}, fall, seen);
        checks++;
        if (SdaOe !== 1'b0 || SclOe !== 1'b0) begin
            errors++;
            $display("FAIL stop_lines: scl=%b sda=%b want 0 0", SclOe, SdaOe);
        end
    endtask

    task automatic test_read();
        int   fall;
        logic seen;
        issue("read1", 3'b100, 1'b0, 8'd8, '{arb: 1'b0, dout: 1'b1, chk_dout: 1'b1,
              cycles: full_cycles(8'd8), starts: 4}, fall, seen);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL read1_sda: sda_oe seen=%b want 0", seen);
        end
        sda_force0 = 1'b1;
        issue("read0", 3'b100, 1'b1, 8'd8, '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b1,
              cycles: full_cycles(8'd8), starts: 4}, fall, seen);
        sda_force0 = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL read0_sda: sda_oe seen=%b want 0", seen);
        end
    endtask

    task automatic test_arb_lost();
        int   fall;
        logic seen;
        sda_force0 = 1'b1;
        issue("arb", 3'b011, 1'b1, 8'd4, '{arb: 1'b1, dout: 1'b0, chk_dout: 1'b1,
              cycles: 2 * (4 + 2), starts: 2}, fall, seen);
        sda_force0 = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL arb_quiet: done=%b busy=%b want 0 0", Done, Busy);
            end
        end
    endtask

    task automatic test_div_zero_nop();
        int   fall;
        logic seen;
        issue("div0", 3'b011, 1'b1, 8'd0, '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b0,
              cycles: full_cycles(8'd0), starts: 4}, fall, seen);
        issue("nop110", 3'b110, 1'b0, 8'd5, '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b1,
              cycles: 0, starts: 0}, fall, seen);
        issue("nop000", 3'b000, 1'b0, 8'd5, '{arb: 1'b0, dout: 1'b0, chk_dout: 1'b0,
              cycles: 0, starts: 0}, fall, seen);
    endtask

    task automatic test_reset_mid_cmd();
        int outs;
        int k;
        @(negedge Clk);
        Cmd = 3'b011; DinBit = 1'b0; Divider = 8'd4; CmdValid = 1'b1;
        @(negedge Clk);
        CmdValid = 1'b0; Cmd = 3'b000;
        outs = 0; k = 0;
        while (outs < 2 && k < 200) begin
            if (TmrOut) outs++;
            @(negedge Clk);
            k++;
        end
        @(negedge Clk);
        checks++;
        if (outs != 2 || Busy !== 1'b1 || SdaOe !== 1'b1 || SclOe !== 1'b0) begin
            errors++;
            $display("FAIL mid_phase_c: outs=%0d busy=%b sda=%b scl=%b want 2 1 1 0", outs, Busy, SdaOe, SclOe);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (SclOe !== 1'b0 || SdaOe !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0 || CmdReady !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: scl=%b sda=%b busy=%b done=%b rdy=%b want 0 0 0 0 0",
                     SclOe, SdaOe, Busy, Done, CmdReady);
        end
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (CmdReady !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: rdy=%b done=%b want 1 0", CmdReady, Done);
        end
        repeat (30) begin
            @(negedge Clk);
            checks++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet: done=%b busy=%b want 0 0", Done, Busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_write();
        test_read();
        test_arb_lost();
        test_div_zero_nop();
        test_reset_mid_cmd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
